// File: rtl/rtr_credit_return.sv
// -----------------------------------------------------------------------------
// rtr_credit_return
//
// Input-port credit return generator. Buffer-slot releases (one bit per VC per
// cycle, any number at once) are accumulated in per-VC pending counters and
// drained round-robin as a single credit per active cycle towards the upstream
// router's output-VC flow control tracker.
//
// Optional feature macro: RTR_CREDIT_RETURN_BYPASS_EN
//   defined   : a release may be granted in the cycle it arrives (1-cycle
//               minimum latency, counter net change 0).
//   undefined : arbiter sees registered counters only (2-cycle latency).
//
// Ports:
//   clk              in   clock
//   reset            in   synchronous active-high reset
//   active           in   clock enable; state updates only when high
//   pop_valid_ivc    in   per-VC slot release strobes
//   fc_event_valid   out  one credit returned this cycle (registered, gated
//                         low while active is low)
//   fc_event_sel_ovc out  one-hot VC of the returned credit, zero when idle
//   fc_active        out  any credit pending or any release present
//   errors_ivc       out  per VC: bit 2v overflow (registered pulse),
//                         bit 2v+1 release while inactive (combinational)
// -----------------------------------------------------------------------------
module rtr_credit_return #(
   parameter int num_vcs     = 4,
   parameter int buffer_size = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   active,
   input  logic [num_vcs-1:0]     pop_valid_ivc,
   output logic                   fc_event_valid,
   output logic [num_vcs-1:0]     fc_event_sel_ovc,
   output logic                   fc_active,
   output logic [2*num_vcs-1:0]   errors_ivc
);

   localparam int buffer_size_per_vc = buffer_size / num_vcs;
   localparam int cnt_width          = $clog2(buffer_size_per_vc + 1);
   localparam logic [cnt_width-1:0] cnt_max = cnt_width'(buffer_size_per_vc);
   localparam logic [cnt_width-1:0] cnt_one = cnt_width'(1);

   logic [cnt_width-1:0] cnt_r [num_vcs];
   logic [num_vcs-1:0]   rr_ptr_r;
   logic                 valid_r;
   logic [num_vcs-1:0]   sel_r;
   logic [num_vcs-1:0]   ovf_r;

   logic [cnt_width-1:0] cnt_nxt_s [num_vcs];
   logic [num_vcs-1:0]   cnt_nz_s;
   logic [num_vcs-1:0]   elig_s;
   logic [num_vcs-1:0]   grant_s;
   logic                 found_s;
   logic [num_vcs-1:0]   ovf_nxt_s;
   logic [num_vcs-1:0]   rr_nxt_s;

   // Eligibility: pending credits, plus same-cycle releases when bypassing.
   always_comb begin
      cnt_nz_s = {num_vcs{1'b0}};
      elig_s   = {num_vcs{1'b0}};
      for (int v = 0; v < num_vcs; v++) begin
         cnt_nz_s[v] = (cnt_r[v] != {cnt_width{1'b0}});
`ifdef RTR_CREDIT_RETURN_BYPASS_EN
         elig_s[v]   = cnt_nz_s[v] | pop_valid_ivc[v];
`else
         elig_s[v]   = cnt_nz_s[v];
`endif
      end
   end

   // Round-robin arbiter: first eligible VC at or after rr_ptr, with wrap.
   // Scan offsets outermost so the nearest eligible VC wins.
   always_comb begin
      grant_s = {num_vcs{1'b0}};
      found_s = 1'b0;
      for (int o = 0; o < num_vcs; o++) begin
         for (int s = 0; s < num_vcs; s++) begin
            grant_s[(s + o) % num_vcs] = grant_s[(s + o) % num_vcs]
                                       | (rr_ptr_r[s] & ~found_s & elig_s[(s + o) % num_vcs]);
            found_s = |grant_s;
         end
      end
      // Pointer moves to the VC after the granted one; holds when no grant.
      rr_nxt_s = found_s ? {grant_s[num_vcs-2:0], grant_s[num_vcs-1]} : rr_ptr_r;
   end

   // Counter next state: +release -grant, saturating at the per-VC depth.
   always_comb begin
      ovf_nxt_s = {num_vcs{1'b0}};
      for (int v = 0; v < num_vcs; v++) begin
         cnt_nxt_s[v] = cnt_r[v];
         if (pop_valid_ivc[v] && !grant_s[v]) begin
            if (cnt_r[v] == cnt_max) begin
               ovf_nxt_s[v] = 1'b1;
               cnt_nxt_s[v] = cnt_r[v];
            end else begin
               cnt_nxt_s[v] = cnt_r[v] + cnt_one;
            end
         end else if (grant_s[v] && !pop_valid_ivc[v]) begin
            cnt_nxt_s[v] = cnt_r[v] - cnt_one;
         end else begin
            cnt_nxt_s[v] = cnt_r[v];
         end
      end
   end

   // State and output registers; everything holds while active is low except
   // the overflow pulse, which must not linger.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int v = 0; v < num_vcs; v++) begin
            cnt_r[v] <= {cnt_width{1'b0}};
         end
         rr_ptr_r <= {{(num_vcs-1){1'b0}}, 1'b1};
         valid_r  <= 1'b0;
         sel_r    <= {num_vcs{1'b0}};
         ovf_r    <= {num_vcs{1'b0}};
      end else if (active) begin
         for (int v = 0; v < num_vcs; v++) begin
            cnt_r[v] <= cnt_nxt_s[v];
         end
         rr_ptr_r <= rr_nxt_s;
         valid_r  <= found_s;
         sel_r    <= grant_s;
         ovf_r    <= ovf_nxt_s;
      end else begin
         ovf_r    <= {num_vcs{1'b0}};
      end
   end

   // Output gating and error/wake signals.
   always_comb begin
      fc_event_valid   = valid_r & active;
      fc_event_sel_ovc = sel_r & {num_vcs{fc_event_valid}};
      fc_active        = (|cnt_nz_s) | (|pop_valid_ivc);
      errors_ivc       = {(2*num_vcs){1'b0}};
      for (int v = 0; v < num_vcs; v++) begin
         errors_ivc[2*v]   = ovf_r[v];
         errors_ivc[2*v+1] = pop_valid_ivc[v] & ~active;
      end
   end

endmodule

// File: tb/tb_rtr_credit_return.sv
// -----------------------------------------------------------------------------
// Testbench for rtr_credit_return (4 VCs, 16-flit buffer, depth 4 per VC).
// A behavioural model tracks pending credit counts as integers, picks the
// round-robin winner by index arithmetic and predicts every output per cycle.
// -----------------------------------------------------------------------------
module tb_rtr_credit_return;

   localparam int NV  = 4;
   localparam int BPV = 4;
`ifdef RTR_CREDIT_RETURN_BYPASS_EN
   localparam int LAT = 1;
`else
   localparam int LAT = 2;
`endif

   logic          clk;
   logic          reset;
   logic          active;
   logic [3:0]    pop_valid_ivc;
   logic          fc_event_valid;
   logic [3:0]    fc_event_sel_ovc;
   logic          fc_active;
   logic [7:0]    errors_ivc;

   int n_cmp  = 0;
   int n_fail = 0;

   // model state
   int mcnt [NV];
   int mrr;
   bit mvalid;
   int msel;
   bit movf [NV];

   rtr_credit_return #(.num_vcs(4), .buffer_size(16)) dut (
      .clk              (clk),
      .reset            (reset),
      .active           (active),
      .pop_valid_ivc    (pop_valid_ivc),
      .fc_event_valid   (fc_event_valid),
      .fc_event_sel_ovc (fc_event_sel_ovc),
      .fc_active        (fc_active),
      .errors_ivc       (errors_ivc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected {valid, sel[3:0], errors[7:0], fc_active} for the current cycle.
   function automatic logic [13:0] exp_vec(input logic [3:0] p, input logic a);
      logic       v;
      logic [3:0] s;
      logic [7:0] e;
      logic       f;
      v = mvalid && a;
      s = v ? 4'(4'b0001 << msel) : 4'b0000;
      e = 8'b0;
      f = (p != 4'b0000);
      for (int i = 0; i < NV; i++) begin
         e[2*i]   = movf[i];
         e[2*i+1] = p[i] & ~a;
         if (mcnt[i] != 0) f = 1'b1;
      end
      return {v, s, e, f};
   endfunction

   // Advance the model across one clock edge.
   task automatic model_edge(input logic [3:0] p, input logic a, input logic r);
      int g;
      int c;
      bit el;
      if (r) begin
         for (int i = 0; i < NV; i++) begin mcnt[i] = 0; movf[i] = 0; end
         mrr = 0; mvalid = 0; msel = 0;
      end else if (a) begin
         g = -1;
         for (int k = 0; k < NV; k++) begin
            int vc;
            vc = (mrr + k) % NV;
`ifdef RTR_CREDIT_RETURN_BYPASS_EN
            el = (mcnt[vc] > 0) || p[vc];
`else
            el = (mcnt[vc] > 0);
`endif
            if (g < 0 && el) g = vc;
         end
         for (int i = 0; i < NV; i++) begin
            c = mcnt[i] + int'(p[i]) - ((g == i) ? 1 : 0);
            movf[i] = (c > BPV);
            mcnt[i] = (c > BPV) ? BPV : c;
         end
         mvalid = (g >= 0);
         if (g >= 0) begin msel = g; mrr = (g + 1) % NV; end
      end else begin
         for (int i = 0; i < NV; i++) movf[i] = 0;
      end
   endtask

   // One clock cycle: drive, sample outputs mid-cycle, then step across the edge.
   task automatic cyc(input logic [3:0] p, input logic a, input logic r,
                      output logic [13:0] got, output logic [13:0] exp);
      pop_valid_ivc = p;
      active        = a;
      reset         = r;
      #1;
      got = {fc_event_valid, fc_event_sel_ovc, errors_ivc, fc_active};
      exp = exp_vec(p, a);
      @(posedge clk);
      model_edge(p, a, r);
      #1;
   endtask

   task automatic do_reset();
      logic [13:0] g, e;
      cyc(4'b0000, 1'b1, 1'b1, g, e);
      cyc(4'b0000, 1'b1, 1'b1, g, e);
   endtask

   task automatic test_reset();
      logic [13:0] g, e;
      do_reset();
      cyc(4'b0000, 1'b1, 1'b0, g, e);
      n_cmp++;
      if (g !== 14'd0) begin
         n_fail++; $display("FAIL reset_zero: got %b want %b", g, 14'd0);
      end
      n_cmp++;
      if (g !== e) begin
         n_fail++; $display("FAIL reset_model: got %b want %b", g, e);
      end
   endtask

   task automatic test_single();
      logic [13:0] g, e;
      int n_cr = 0;
      int at   = -1;
      do_reset();
      for (int i = 0; i < 6; i++) begin
         cyc((i == 0) ? 4'b0100 : 4'b0000, 1'b1, 1'b0, g, e);
         n_cmp++;
         if (g !== e) begin
            n_fail++; $display("FAIL single cyc%0d: got %b want %b", i, g, e);
         end
         if (g[13]) begin
            n_cr++; at = i;
            n_cmp++;
            if (g[12:9] !== 4'b0100) begin
               n_fail++; $display("FAIL single_sel: got %b want 0100", g[12:9]);
            end
         end
      end
      n_cmp++;
      if (n_cr != 1 || at != LAT) begin
         n_fail++; $display("FAIL single_latency: got %0d credits at %0d want 1 at %0d", n_cr, at, LAT);
      end
      n_cmp++;
      if (g[0] !== 1'b0) begin
         n_fail++; $display("FAIL single_fc_active: got %b want 0", g[0]);
      end
   endtask

   task automatic test_all_four();
      logic [13:0] g, e;
      logic [3:0] order [$];
      do_reset();
      for (int i = 0; i < 8; i++) begin
         cyc((i == 0) ? 4'b1111 : 4'b0000, 1'b1, 1'b0, g, e);
         n_cmp++;
         if (g !== e) begin
            n_fail++; $display("FAIL all_four cyc%0d: got %b want %b", i, g, e);
         end
         if (g[13]) order.push_back(g[12:9]);
      end
      n_cmp++;
      if (order.size() != 4) begin
         n_fail++; $display("FAIL all_four_count: got %0d want 4", order.size());
      end else begin
         n_cmp++;
         if (order[0] !== 4'b0001 || order[1] !== 4'b0010 ||
             order[2] !== 4'b0100 || order[3] !== 4'b1000) begin
            n_fail++; $display("FAIL all_four_order: got %b %b %b %b want 0001 0010 0100 1000",
                               order[0], order[1], order[2], order[3]);
         end
      end
      n_cmp++;
      if (g[0] !== 1'b0) begin
         n_fail++; $display("FAIL all_four_drained: fc_active got %b want 0", g[0]);
      end
   endtask

   task automatic test_alternate();
      logic [13:0] g, e;
      logic [3:0] p;
      int n_cr = 0;
      int n_err = 0;
      do_reset();
      for (int i = 0; i < 16; i++) begin
         p = (i < 2) ? 4'b1000 : ((i < 10) ? 4'b0010 : 4'b0000);
         cyc(p, 1'b1, 1'b0, g, e);
         n_cmp++;
         if (g !== e) begin
            n_fail++; $display("FAIL alternate cyc%0d: got %b want %b", i, g, e);
         end
         if (g[13]) n_cr++;
         if (g[8:1] != 8'b0) n_err++;
      end
      n_cmp++;
      if (n_cr != 10 || n_err != 0) begin
         n_fail++; $display("FAIL alternate_total: got %0d credits %0d err cycles want 10 and 0", n_cr, n_err);
      end
   endtask

   task automatic test_overflow();
      logic [13:0] g, e;
      int n_ovf = 0;
      int n_cr  = 0;
      do_reset();
      for (int i = 0; i < 30; i++) begin
         cyc((i < 8) ? 4'b1111 : 4'b0000, 1'b1, 1'b0, g, e);
         n_cmp++;
         if (g !== e) begin
            n_fail++; $display("FAIL overflow cyc%0d: got %b want %b", i, g, e);
         end
         if (g[13]) n_cr++;
         for (int v = 0; v < NV; v++) if (g[1 + 2*v]) n_ovf++;
      end
      // 32 releases, one credit per cycle out, counters cap at 4 each.
      n_cmp++;
      if (n_ovf == 0 || n_cr + n_ovf != 32) begin
         n_fail++; $display("FAIL overflow_balance: got %0d credits %0d overflows want sum 32", n_cr, n_ovf);
      end
   endtask

   task automatic test_inactive();
      logic [13:0] g, e;
      int n_cr = 0;
      do_reset();
      for (int i = 0; i < 16; i++) begin
         if (i == 0)
            cyc(4'b1111, 1'b1, 1'b0, g, e);
         else if (i < 6)
            cyc(4'b0100, 1'b0, 1'b0, g, e);
         else
            cyc(4'b0000, 1'b1, 1'b0, g, e);
         n_cmp++;
         if (g !== e) begin
            n_fail++; $display("FAIL inactive cyc%0d: got %b want %b", i, g, e);
         end
         if (i >= 1 && i < 6) begin
            n_cmp++;
            if (g[6] !== 1'b1 || g[13] !== 1'b0) begin
               n_fail++; $display("FAIL inactive_err5 cyc%0d: got err5=%b valid=%b want 1 0", i, g[6], g[13]);
            end
         end
         if (g[13]) n_cr++;
      end
      n_cmp++;
      if (n_cr != 4) begin
         n_fail++; $display("FAIL inactive_total: got %0d want 4", n_cr);
      end
   endtask

   task automatic test_reset_mid();
      logic [13:0] g, e;
      int n_cr = 0;
      do_reset();
      cyc(4'b0001, 1'b1, 1'b0, g, e);
      cyc(4'b1111, 1'b1, 1'b0, g, e);
      cyc(4'b1111, 1'b1, 1'b0, g, e);
      cyc(4'b0000, 1'b1, 1'b1, g, e);
      for (int i = 0; i < 6; i++) begin
         cyc(4'b0000, 1'b1, 1'b0, g, e);
         n_cmp++;
         if (g !== e) begin
            n_fail++; $display("FAIL reset_mid cyc%0d: got %b want %b", i, g, e);
         end
         if (g[13] || g[0]) n_cr++;
      end
      n_cmp++;
      if (n_cr != 0) begin
         n_fail++; $display("FAIL reset_mid_quiet: got %0d busy cycles want 0", n_cr);
      end
   endtask

   task automatic test_random();
      logic [13:0] g, e;
      logic [3:0] p;
      logic a, r;
      do_reset();
      for (int i = 0; i < 600; i++) begin
         p = 4'($urandom_range(0, 15));
         if (i % 100 > 60) p = p & 4'($urandom_range(0, 15));
         a = ($urandom_range(0, 7) != 0);
         r = ($urandom_range(0, 149) == 0);
         cyc(p, a, r, g, e);
         n_cmp++;
         if (g !== e) begin
            n_fail++; $display("FAIL random cyc%0d: got %b want %b (pop %b act %b)", i, g, e, p, a);
         end
      end
   endtask

   initial begin
      reset = 1'b1;
      active = 1'b1;
      pop_valid_ivc = 4'b0000;
      for (int i = 0; i < NV; i++) begin mcnt[i] = 0; movf[i] = 0; end
      mrr = 0; mvalid = 0; msel = 0;
      @(posedge clk);
      #1;
      test_reset();
      test_single();
      test_all_four();
      test_alternate();
      test_overflow();
      test_inactive();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
